// File: rtl/ram_port_arbiter_pkg.sv
// Shared RS5 arbitration types: master index enum and master count.
// Latency: n/a (types only).
// Backpressure: n/a.
package RS5_pkg;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_master_e;

    localparam int ARB_MASTERS = 2;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both master request ports and the shared RAM port.
// Latency: n/a (wiring only).
// Backpressure: a master holds its request until its gnt is seen high.
interface ram_port_arbiter_if #(
    parameter int MEM_WIDTH = 65536
);
    localparam int AW = $clog2(MEM_WIDTH);

    logic          m0_req_i;
    logic [3:0]    m0_we_i;
    logic [AW-1:0] m0_addr_i;
    logic [31:0]   m0_data_i;
    logic          m0_gnt_o;
    logic          m0_rvalid_o;
    logic [31:0]   m0_data_o;

    logic          m1_req_i;
    logic [3:0]    m1_we_i;
    logic [AW-1:0] m1_addr_i;
    logic [31:0]   m1_data_i;
    logic          m1_gnt_o;
    logic          m1_rvalid_o;
    logic [31:0]   m1_data_o;

    logic          ram_en_o;
    logic [3:0]    ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_data_o;
    logic [31:0]   ram_data_i;

    // Arbiter side
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        input  ram_data_i,
        output m0_gnt_o, m0_rvalid_o, m0_data_o,
        output m1_gnt_o, m1_rvalid_o, m1_data_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_data_o
    );

    // Requesting masters plus the RAM returning read data
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        output ram_data_i,
        input  m0_gnt_o, m0_rvalid_o, m0_data_o,
        input  m1_gnt_o, m1_rvalid_o, m1_data_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_data_o
    );

endinterface

// File: rtl/ram_port_arbiter_pick.sv
// Combinational one-hot grant pick; ARB_ROUND_ROBIN_EN selects round-robin, else M1 wins contention.
// Latency: 0 cycles.
// Backpressure: the losing request simply stays unselected this cycle.
module arb_pick
    import RS5_pkg::*;
(
    input  logic [ARB_MASTERS-1:0] req,
    input  arb_master_e            last,
    output logic [ARB_MASTERS-1:0] grant
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef ARB_ROUND_ROBIN_EN
                grant = (last == ARB_M1) ? 2'b01 : 2'b10;
`else
                grant = 2'b10;
`endif
            end
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one sync-read RAM port between fetch (M0) and load/store (M1); policy via ARB_ROUND_ROBIN_EN.
// Latency: gnt same cycle as req; read data/rvalid one cycle after gnt.
// Backpressure: loser sees gnt=0 and must hold its request stable.
module ram_port_arbiter
    import RS5_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    ram_port_arbiter_if.slave bus
);

    logic [ARB_MASTERS-1:0] req;
    logic [ARB_MASTERS-1:0] pick;
    logic [ARB_MASTERS-1:0] gnt;
    logic                   rd_pending;
    arb_master_e            rd_owner;
    arb_master_e            last;
    arb_master_e            gnt_idx;

    assign req = {bus.m1_req_i, bus.m0_req_i};

    arb_pick u_pick (
        .req   (req),
        .last  (last),
        .grant (pick)
    );

    assign gnt          = reset_n ? pick : '0;
    assign gnt_idx      = gnt[1] ? ARB_M1 : ARB_M0;
    assign bus.m0_gnt_o = gnt[0];
    assign bus.m1_gnt_o = gnt[1];

    always_comb begin
        bus.ram_en_o   = 1'b0;
        bus.ram_we_o   = '0;
        bus.ram_addr_o = '0;
        bus.ram_data_o = '0;
        if (gnt[1]) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_we_o   = bus.m1_we_i;
            bus.ram_addr_o = bus.m1_addr_i;
            bus.ram_data_o = bus.m1_data_i;
        end else if (gnt[0]) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_we_o   = bus.m0_we_i;
            bus.ram_addr_o = bus.m0_addr_i;
            bus.ram_data_o = bus.m0_data_i;
        end
    end

    // rd_owner only moves on a granted read so it always names the in-flight reader
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= ARB_M0;
            last       <= ARB_M1;
        end else begin
            rd_pending <= bus.ram_en_o && (bus.ram_we_o == '0);
            if (bus.ram_en_o && (bus.ram_we_o == '0)) begin
                rd_owner <= gnt_idx;
            end
            if (bus.ram_en_o) begin
                last <= gnt_idx;
            end
        end
    end

    assign bus.m0_rvalid_o = rd_pending && (rd_owner == ARB_M0);
    assign bus.m1_rvalid_o = rd_pending && (rd_owner == ARB_M1);
    assign bus.m0_data_o   = bus.ram_data_i;
    assign bus.m1_data_o   = bus.ram_data_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a byte-addressed sync-read RAM model.
module tb_ram_port_arbiter;
    import RS5_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.MEM_WIDTH(65536)) bus ();

    ram_port_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // RAM model: one-cycle read latency, byte writes, backdoor preload port
    logic [7:0]  mem [0:65535];
    logic [31:0] rd_q = '0;
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [31:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            for (int b = 0; b < 4; b++) mem[int'(pre_addr) + b] <= pre_dat[8*b +: 8];
        end else if (bus.ram_en_o) begin
            if (bus.ram_we_o == 4'b0000) begin
                for (int b = 0; b < 4; b++) rd_q[8*b +: 8] <= mem[int'(bus.ram_addr_o) + b];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_we_o[b]) mem[int'(bus.ram_addr_o) + b] <= bus.ram_data_o[8*b +: 8];
            end
        end
    end
    assign bus.ram_data_i = rd_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic masters_idle();
        bus.m0_req_i = 1'b0; bus.m0_we_i = 4'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 4'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_dat = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        masters_idle();
        reset_n = 1'b0;
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 16'h0010;
        tick();
        tick();
        #3;
        vectors++;
        if (bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got m0=%b m1=%b want 0 0", bus.m0_gnt_o, bus.m1_gnt_o);
        end
        vectors++;
        if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: got m0=%b m1=%b want 0 0", bus.m0_rvalid_o, bus.m1_rvalid_o);
        end
        masters_idle();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        masters_idle();
        tick();
        #3;
        vectors++;
        if (bus.ram_en_o !== 1'b0 || bus.ram_we_o !== 4'b0 || bus.ram_addr_o !== 16'h0) begin
            errors++;
            $display("FAIL idle_ram: got en=%b we=%b addr=%h want 0 0000 0000",
                     bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o);
        end
        vectors++;
        if (bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b0 ||
            bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_handshake: got gnt=%b%b rvalid=%b%b want 00 00",
                     bus.m1_gnt_o, bus.m0_gnt_o, bus.m1_rvalid_o, bus.m0_rvalid_o);
        end
    endtask

    task automatic test_single_read();
        preload(16'h0010, 32'h11223344);
        bus.m0_req_i = 1'b1; bus.m0_we_i = 4'b0; bus.m0_addr_i = 16'h0010;
        #3;
        vectors++;
        if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: got m0=%b m1=%b want 1 0", bus.m0_gnt_o, bus.m1_gnt_o);
        end
        vectors++;
        if (bus.ram_en_o !== 1'b1 || bus.ram_we_o !== 4'b0 || bus.ram_addr_o !== 16'h0010) begin
            errors++;
            $display("FAIL single_ram: got en=%b we=%b addr=%h want 1 0000 0010",
                     bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o);
        end
        tick();
        masters_idle();
        #3;
        vectors++;
        if (bus.m0_rvalid_o !== 1'b1 || bus.m1_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rvalid: got m0=%b m1=%b want 1 0", bus.m0_rvalid_o, bus.m1_rvalid_o);
        end
        vectors++;
        if (bus.m0_data_o !== 32'h11223344) begin
            errors++;
            $display("FAIL single_data: got %h want 11223344", bus.m0_data_o);
        end
        tick();
        #3;
        vectors++;
        if (bus.m0_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rvalid_drop: got %b want 0", bus.m0_rvalid_o);
        end
    endtask

    task automatic test_write_then_read();
        preload(16'h0020, 32'h55667788);
        bus.m1_req_i = 1'b1; bus.m1_we_i = 4'b0011; bus.m1_addr_i = 16'h0020; bus.m1_data_i = 32'hAABBCCDD;
        #3;
        vectors++;
        if (bus.m1_gnt_o !== 1'b1 || bus.m0_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL write_gnt: got m0=%b m1=%b want 0 1", bus.m0_gnt_o, bus.m1_gnt_o);
        end
        vectors++;
        if (bus.ram_we_o !== 4'b0011 || bus.ram_data_o !== 32'hAABBCCDD || bus.ram_addr_o !== 16'h0020) begin
            errors++;
            $display("FAIL write_ram: got we=%b data=%h addr=%h want 0011 aabbccdd 0020",
                     bus.ram_we_o, bus.ram_data_o, bus.ram_addr_o);
        end
        tick();
        masters_idle();
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 16'h0020;
        #3;
        vectors++;
        if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid: got m0=%b m1=%b want 0 0", bus.m0_rvalid_o, bus.m1_rvalid_o);
        end
        vectors++;
        if (bus.m0_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_gnt: got %b want 1", bus.m0_gnt_o);
        end
        tick();
        masters_idle();
        #3;
        vectors++;
        if (bus.m0_rvalid_o !== 1'b1 || bus.m0_data_o !== 32'h5566CCDD) begin
            errors++;
            $display("FAIL wr_rd_data: got rvalid=%b data=%h want 1 5566ccdd", bus.m0_rvalid_o, bus.m0_data_o);
        end
    endtask

    task automatic test_contention();
        logic        prev_vld;
        logic        prev_win;
        logic        exp_win;
        logic [31:0] exp_dat;
        preload(16'h0100, 32'hA0A00100);
        preload(16'h0200, 32'hB1B10200);
        masters_idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 16'h0100;
        bus.m1_req_i = 1'b1; bus.m1_addr_i = 16'h0200;
        prev_vld = 1'b0;
        prev_win = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) masters_idle();
            #3;
            if (c < 6) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_win = (c % 2 == 1);
`else
                exp_win = 1'b1;
`endif
                vectors++;
                if (bus.m1_gnt_o !== exp_win || bus.m0_gnt_o !== !exp_win) begin
                    errors++;
                    $display("FAIL contend_gnt[%0d]: got m1=%b m0=%b want m1=%b m0=%b",
                             c, bus.m1_gnt_o, bus.m0_gnt_o, exp_win, !exp_win);
                end
            end
            if (prev_vld) begin
                exp_dat = prev_win ? 32'hB1B10200 : 32'hA0A00100;
                vectors++;
                if (bus.m1_rvalid_o !== prev_win || bus.m0_rvalid_o !== !prev_win ||
                    bus.m0_data_o !== exp_dat) begin
                    errors++;
                    $display("FAIL contend_ret[%0d]: got rv m1=%b m0=%b data=%h want m1=%b m0=%b data=%h",
                             c, bus.m1_rvalid_o, bus.m0_rvalid_o, bus.m0_data_o, prev_win, !prev_win, exp_dat);
                end
            end
            prev_vld = 1'b1;
            prev_win = exp_win;
            tick();
        end
        masters_idle();
    endtask

    task automatic test_reset_during_read();
        bus.m0_req_i = 1'b1; bus.m0_we_i = 4'b0; bus.m0_addr_i = 16'h0010;
        #3;
        vectors++;
        if (bus.m0_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_gnt: got %b want 1", bus.m0_gnt_o);
        end
        reset_n = 1'b0;
        tick();
        masters_idle();
        #3;
        vectors++;
        if (bus.m0_rvalid_o !== 1'b0 || bus.m1_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_rd_rvalid: got m0=%b m1=%b want 0 0", bus.m0_rvalid_o, bus.m1_rvalid_o);
        end
        tick();
        reset_n = 1'b1;
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 16'h0100;
        bus.m1_req_i = 1'b1; bus.m1_addr_i = 16'h0200;
        #3;
        vectors++;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.m0_gnt_o !== 1'b1 || bus.m1_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_win: got m0=%b m1=%b want 1 0", bus.m0_gnt_o, bus.m1_gnt_o);
        end
`else
        if (bus.m0_gnt_o !== 1'b0 || bus.m1_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_win: got m0=%b m1=%b want 0 1", bus.m0_gnt_o, bus.m1_gnt_o);
        end
`endif
        tick();
        masters_idle();
        tick();
    endtask

    initial begin
        masters_idle();
        test_reset();
        test_idle();
        test_single_read();
        test_write_then_read();
        test_contention();
        test_reset_during_read();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
